// File: rtl/uart_pkg.sv
// Shared types and width helpers for the parametrised UART receiver.
// The optional parity feature is enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HI
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 5;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    // Bit-timer width: must hold CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

    // Bit-index width: must hold DATA_BITS-1.
    function automatic int idx_width(input int data_bits);
        return (data_bits > 2) ? $clog2(data_bits) : 1;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide at any fill level.
// Head data reads as zero while empty so the read port is clean after reset.
`timescale 1ns/1ps
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = DEF_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     xreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!xreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count define validity, and rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (start + DATA_BITS + [parity] + stop) feeding a FWFT FIFO with valid/ready read port.
// Define UART_RX_PARITY_EN to expect a parity bit before the stop bit.
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          xreset,
    input  logic                          rs_rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          parity_err
);

    localparam int              CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam int              IDX_W    = idx_width(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 sync1_q;
    logic                 rx_s_q;
    rx_state_t            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 stop_sample;
    logic                 good_frame;
    logic                 fifo_full;
    logic                 fifo_empty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!xreset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rs_rx;
            rx_s_q  <= sync1_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;

    always_ff @(posedge clk) begin
        if (!xreset) begin
            par_bad_q <= 1'b0;
        end else if (state_q == PARITY && cnt_q == '0) begin
            par_bad_q <= rx_s_q ^ (^shift_q) ^ PARITY_ODD[0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!xreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_BIT;
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!rx_s_q) begin
                        state_q   <= DATA;
                        cnt_q     <= FULL_BIT;
                        bit_idx_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        cnt_q     <= FULL_BIT;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q   <= FULL_BIT;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= rx_s_q ? IDLE : WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    // A held-low break line must return high before another start bit counts.
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stop_sample = (state_q == STOP) && (cnt_q == '0);
    assign frame_err   = stop_sample & ~rx_s_q;

`ifdef UART_RX_PARITY_EN
    assign good_frame  = stop_sample & rx_s_q & ~par_bad_q;
    assign parity_err  = stop_sample & rx_s_q & par_bad_q;
`else
    assign good_frame  = stop_sample & rx_s_q;
    assign parity_err  = 1'b0;
`endif

    // A full FIFO still accepts the word when the consumer pops in the same cycle.
    assign overrun  = good_frame & fifo_full & ~rd_ready;
    assign rd_valid = ~fifo_empty;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .xreset  (xreset),
        .push    (good_frame),
        .wr_data (shift_q),
        .pop     (rd_valid & rd_ready),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames push expected bytes, a monitor pops and compares on each read handshake.
// Parity scenario runs only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB   = 5;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          xreset = 1'b0;
    logic          rs_rx = 1'b1;
    logic          rd_ready = 1'b0;
    logic [DB-1:0] rd_data;
    logic          rd_valid;
    logic [CW-1:0] fifo_count;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_ferr = 0;
    int            n_ovr = 0;
    int            n_perr = 0;
    logic [DB-1:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .FIFO_DEPTH   (DEPTH),
        .PARITY_ODD   (0)
    ) dut (
        .clk        (clk),
        .xreset     (xreset),
        .rs_rx      (rs_rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts error pulses and checks each accepted word against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (xreset) begin
                if (frame_err)  n_ferr++;
                if (overrun)    n_ovr++;
                if (parity_err) n_perr++;
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) check("unexpected_pop", 32'(rd_data) | 32'h100, 32'h0);
                    else                   check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rs_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`else
        if (par_b) rs_rx = 1'b1;
`endif
        drive_bit(stop_b);
        rs_rx = 1'b1;
    endtask

    task automatic drain(input string name);
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && rd_valid; i++) @(negedge clk);
        rd_ready = 1'b0;
        check({name, "_drained"}, 32'(rd_valid), 32'd0);
        check({name, "_scoreboard_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_pulses(input string name, input int f0, input int o0, input int p0,
                                input int df, input int dov, input int dp);
        check({name, "_frame_err"},  n_ferr - f0, df);
        check({name, "_overrun"},    n_ovr - o0,  dov);
        check({name, "_parity_err"}, n_perr - p0, dp);
    endtask

    initial begin
        int f0, o0, p0;

        // Reset state
        idle(3);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'd0);
        xreset = 1'b1;
        idle(5);

        // 1: single frame 0_10010110_1 -> 0x69
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1, 1'b0);
        idle(2);
        check("t1_rd_valid", 32'(rd_valid), 32'd1);
        check("t1_count", 32'(fifo_count), 32'd1);
        check("t1_head", 32'(rd_data), 32'd105);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        idle(1);
        check("t1_count_after_pop", 32'(fifo_count), 32'd0);
        check("t1_rd_valid_after_pop", 32'(rd_valid), 32'd0);
        check_pulses("t1", f0, o0, p0, 0, 0, 0);

        // 2: back-to-back 0x07, 0x00 with consumer always ready
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        rd_ready = 1'b1;
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h00);
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        idle(3);
        rd_ready = 1'b0;
        check("t2_scoreboard_empty", exp_q.size(), 32'd0);
        check("t2_count", 32'(fifo_count), 32'd0);
        check_pulses("t2", f0, o0, p0, 0, 0, 0);

        // 3: five frames into a 4-deep FIFO with no reads -> one overrun, oldest kept
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        check("t3_count_full", 32'(fifo_count), 32'd4);
        send_frame(8'h99, 1'b1, 1'b0);
        idle(2);
        check("t3_count_after_overrun", 32'(fifo_count), 32'd4);
        check("t3_head", 32'(rd_data), 32'h11);
        check_pulses("t3", f0, o0, p0, 0, 1, 0);
        drain("t3");

        // 4: bad stop bit, line held low 20 bit-times, then a good 0x55
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        send_frame(8'h3C, 1'b0, 1'b0);
        rs_rx = 1'b0;
        idle(20 * CPB);
        rs_rx = 1'b1;
        idle(10);
        check("t4_count_after_break", 32'(fifo_count), 32'd0);
        check_pulses("t4", f0, o0, p0, 1, 0, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(2);
        check("t4_count_good", 32'(fifo_count), 32'd1);
        drain("t4");

        // 5: 20 ns glitch on the idle line
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        rs_rx = 1'b0;
        #20;
        rs_rx = 1'b1;
        idle(30);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check_pulses("t5", f0, o0, p0, 0, 0, 0);

        // 6: reset mid-data with two words queued, then 0xA3 intact
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        idle(2);
        check("t6_count_before_reset", 32'(fifo_count), 32'd2);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        xreset = 1'b0;
        rs_rx  = 1'b1;
        idle(2);
        check("t6_count_in_reset", 32'(fifo_count), 32'd0);
        check("t6_rd_valid_in_reset", 32'(rd_valid), 32'd0);
        check("t6_rd_data_in_reset", 32'(rd_data), 32'd0);
        xreset = 1'b1;
        idle(10);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 1'b0);
        idle(2);
        check("t6_count_after", 32'(fifo_count), 32'd1);
        check_pulses("t6", f0, o0, p0, 0, 0, 0);
        drain("t6");

`ifdef UART_RX_PARITY_EN
        // 7: even parity on 0x69 (four ones) -> parity bit 0 good, 1 bad
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1, 1'b0);
        idle(2);
        check("t7_count_good_parity", 32'(fifo_count), 32'd1);
        drain("t7a");
        send_frame(8'h69, 1'b1, 1'b1);
        idle(2);
        check("t7_count_bad_parity", 32'(fifo_count), 32'd0);
        check_pulses("t7", f0, o0, p0, 0, 0, 1);
`endif

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
